vector_ram_gather: RTL and testbench



---
 rtl/vector_ram_gather.sv | 182 ++++++++++++++++++
 tb/tb_vector_ram_gather.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_ram_gather.sv
// Gathers LANES consecutive RAM elements into one flattened vector, with a done pulse.
// Define VGATHER_STRIDE_EN to add a per-request address stride port (default stride 1).
module vector_ram_gather #(
    parameter int LANES  = 9,
    parameter int ELEM_W = 9,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
`ifdef VGATHER_STRIDE_EN
    input  logic [ADDR_W-1:0]       stride,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_rden,
    input  logic [ELEM_W-1:0]       mem_q,
    output logic [LANES*ELEM_W-1:0] vec_out
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [LANE_W-1:0]             issue_cnt;
    logic [LANE_W-1:0]             cnt_next;
    logic [ADDR_W-1:0]             addr_next;
    logic                          rden_next;
    logic [ADDR_W-1:0]             stride_q;
    logic                          accept;
    logic                          last_issue;
    logic                          tail_vld;
    logic [LANE_W-1:0]             tail_lane;
    logic                          capture_last;
    logic [(LANES-1)*ELEM_W-1:0]   staging;
    logic [LANES*ELEM_W-1:0]       vec_next;

`ifdef VGATHER_STRIDE_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stride_q <= '0;
        end else if (accept) begin
            stride_q <= stride;
        end
    end
`else
    assign stride_q = ADDR_W'(1);
`endif

    // Lane-tag pipe: aligns each issued lane index with the cycle its data is on mem_q.
    generate
        if (RD_LAT == 0) begin : g_no_dly
            assign tail_vld  = mem_rden;
            assign tail_lane = issue_cnt;
        end else begin : g_dly
            logic [RD_LAT-1:0] dly_vld;
            logic [LANE_W-1:0] dly_lane [RD_LAT];

            always_ff @(posedge clk) begin
                if (!reset) begin
                    dly_vld <= '0;
                    for (int i = 0; i < RD_LAT; i++) begin
                        dly_lane[i] <= '0;
                    end
                end else begin
                    // NOTE: non-blocking assignments let every stage shift from its
                    // pre-edge value, so stage order inside the block does not matter.
                    dly_vld[0]  <= mem_rden;
                    dly_lane[0] <= issue_cnt;
                    for (int i = 1; i < RD_LAT; i++) begin
                        dly_vld[i]  <= dly_vld[i-1];
                        dly_lane[i] <= dly_lane[i-1];
                    end
                end
            end

            assign tail_vld  = dly_vld[RD_LAT-1];
            assign tail_lane = dly_lane[RD_LAT-1];
        end
    endgenerate

    assign accept       = (state == S_IDLE) && start;
    assign last_issue   = (state == S_ISSUE) && (issue_cnt == LAST_LANE);
    assign capture_last = tail_vld && (tail_lane == LAST_LANE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (capture_last) begin
                    state_next = S_IDLE;
                end else if (last_issue) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (capture_last) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        rden_next = mem_rden;
        addr_next = mem_addr;
        cnt_next  = issue_cnt;
        if (accept) begin
            rden_next = 1'b1;
            addr_next = base_addr;
            cnt_next  = '0;
        end else if (state == S_ISSUE) begin
            if (last_issue) begin
                rden_next = 1'b0;
            end else begin
                addr_next = mem_addr + stride_q;
                cnt_next  = issue_cnt + LANE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rden  <= 1'b0;
            mem_addr  <= '0;
            issue_cnt <= '0;
        end else begin
            busy      <= (state_next != S_IDLE);
            done      <= capture_last;
            mem_rden  <= rden_next;
            mem_addr  <= addr_next;
            issue_cnt <= cnt_next;
        end
    end

    // NOTE: staging needs no reset; every lane is rewritten before vec_out ever loads it.
    always_ff @(posedge clk) begin
        if (tail_vld && !capture_last) begin
            staging[int'(tail_lane)*ELEM_W +: ELEM_W] <= mem_q;
        end
    end

    assign vec_next = {mem_q, staging};

    // The final element bypasses staging so the whole vector updates on one edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vec_out <= '0;
        end else if (capture_last) begin
            vec_out <= vec_next;
        end
    end

endmodule

// File: tb/tb_vector_ram_gather.sv
// Scoreboard bench for vector_ram_gather: RAM model, address/vector expectation queues.
// Exercises the stride port as well when VGATHER_STRIDE_EN is defined.
module tb_vector_ram_gather;

    localparam int LANES  = 9;
    localparam int ELEM_W = 9;
    localparam int ADDR_W = 32;
    localparam int RD_LAT = 1;
    localparam int VEC_W  = LANES * ELEM_W;
    localparam int LAT    = LANES + RD_LAT;

    typedef struct {
        logic [VEC_W-1:0] vec;
        int               cyc;
    } exp_t;

    logic              clk       = 1'b0;
    logic              reset     = 1'b0;
    logic              start     = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rden;
    logic [ELEM_W-1:0] mem_q     = '0;
    logic [VEC_W-1:0]  vec_out;
`ifdef VGATHER_STRIDE_EN
    logic [ADDR_W-1:0] stride    = 32'd1;
`endif

    logic [ELEM_W-1:0] ram [logic [ADDR_W-1:0]];
    logic [ADDR_W-1:0] exp_addr_q [$];
    exp_t              exp_vec_q [$];

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int rden_cnt = 0;

    always #5 clk = ~clk;

    vector_ram_gather #(
        .LANES (LANES),
        .ELEM_W(ELEM_W),
        .ADDR_W(ADDR_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base_addr(base_addr),
`ifdef VGATHER_STRIDE_EN
        .stride   (stride),
`endif
        .busy     (busy),
        .done     (done),
        .mem_addr (mem_addr),
        .mem_rden (mem_rden),
        .mem_q    (mem_q),
        .vec_out  (vec_out)
    );

    // One-cycle-latency RAM model.
    always @(posedge clk) begin
        if (mem_rden) begin
            mem_q <= ram.exists(mem_addr) ? ram[mem_addr] : '0;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        logic [ADDR_W-1:0] a;
        exp_t              e;
        if (mem_rden === 1'b1) begin
            rden_cnt++;
            checks++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL addr_unexpected: mem_addr=%h, required no read", mem_addr);
            end else begin
                a = exp_addr_q.pop_front();
                if (mem_addr !== a) begin
                    errors++;
                    $display("FAIL addr_seq: mem_addr=%h, required %h", mem_addr, a);
                end
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            checks++;
            if (exp_vec_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: done=1 at cycle %0d, required 0", cyc);
            end else begin
                e = exp_vec_q.pop_front();
                if (vec_out !== e.vec) begin
                    errors++;
                    $display("FAIL vec_out: got=%h, required %h", vec_out, e.vec);
                end
                checks++;
                if (cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL done_cycle: got=%0d, required %0d", cyc, e.cyc);
                end
            end
        end
    end

    function automatic logic [VEC_W-1:0] model_vec(input logic [ADDR_W-1:0] base,
                                                   input logic [ADDR_W-1:0] str);
        logic [VEC_W-1:0]  v;
        logic [ADDR_W-1:0] ad;
        v = '0;
        for (int k = 0; k < LANES; k++) begin
            ad = base + ADDR_W'(k) * str;
            v[k*ELEM_W +: ELEM_W] = ram.exists(ad) ? ram[ad] : '0;
        end
        return v;
    endfunction

    task automatic fill_ram(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] str);
        for (int k = 0; k < LANES; k++) begin
            ram[base + ADDR_W'(k) * str] = ELEM_W'($urandom);
        end
    endtask

    // Called just after a negedge; start is sampled at the following posedge.
    task automatic drive_start(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] str);
        exp_t e;
        base_addr = base;
`ifdef VGATHER_STRIDE_EN
        stride = str;
`endif
        start = 1'b1;
        for (int k = 0; k < LANES; k++) begin
            exp_addr_q.push_back(base + ADDR_W'(k) * str);
        end
        e.vec = model_vec(base, str);
        e.cyc = cyc + 1 + LAT;
        exp_vec_q.push_back(e);
        @(negedge clk);
        start     = 1'b0;
        base_addr = $urandom;
`ifdef VGATHER_STRIDE_EN
        stride = $urandom;
`endif
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got=%b, required 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got=%b, required 0", done); end
        if (mem_rden !== 1'b0) begin errors++; $display("FAIL reset_rden: got=%b, required 0", mem_rden); end
        if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got=%h, required 0", mem_addr); end
        if (vec_out !== '0) begin errors++; $display("FAIL reset_vec: got=%h, required 0", vec_out); end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        bit ok;
        for (int i = 0; i < LANES; i++) ram[32'h10 + i] = ELEM_W'(i + 1);
        @(negedge clk);
        rden_cnt = 0;
        drive_start(32'h10, 32'd1);
        wait_done(LAT + 5, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout: done=0, required 1"); end
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if (vec_out[i*ELEM_W +: ELEM_W] !== ELEM_W'(i + 1)) begin
                errors++;
                $display("FAIL basic_lane%0d: got=%h, required %h", i, vec_out[i*ELEM_W +: ELEM_W], i + 1);
            end
        end
        checks += 3;
        if (rden_cnt !== LANES) begin errors++; $display("FAIL basic_rden_cycles: got=%0d, required %0d", rden_cnt, LANES); end
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got=%b, required 0", busy); end
        if (exp_addr_q.size() !== 0) begin errors++; $display("FAIL basic_addr_left: got=%0d, required 0", exp_addr_q.size()); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got=%b, required 0", done); end
    endtask

    task automatic test_sign();
        bit ok;
        fill_ram(32'h40, 32'd1);
        ram[32'h40] = 9'h1FF;
        ram[32'h48] = 9'h100;
        @(negedge clk);
        drive_start(32'h40, 32'd1);
        wait_done(LAT + 5, ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL sign_timeout: done=0, required 1"); end
        if (vec_out[8:0] !== 9'h1FF) begin errors++; $display("FAIL sign_lane0: got=%h, required 1ff", vec_out[8:0]); end
        if (vec_out[80:72] !== 9'h100) begin errors++; $display("FAIL sign_lane8: got=%h, required 100", vec_out[80:72]); end
    endtask

    task automatic test_busy_start();
        bit ok;
        fill_ram(32'h60, 32'd1);
        @(negedge clk);
        drive_start(32'h60, 32'd1);
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid: got=%b, required 1", busy); end
        done_cnt  = 0;
        base_addr = 32'h99;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(LAT + 5, ok);
        repeat (LAT + 5) @(negedge clk);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL busy_timeout: done=0, required 1"); end
        if (done_cnt !== 1) begin errors++; $display("FAIL busy_done_count: got=%0d, required 1", done_cnt); end
        if (exp_addr_q.size() !== 0) begin errors++; $display("FAIL busy_addr_left: got=%0d, required 0", exp_addr_q.size()); end
    endtask

    task automatic test_back_to_back();
        bit               ok;
        logic [VEC_W-1:0] first;
        fill_ram(32'h70, 32'd1);
        fill_ram(32'h20, 32'd1);
        first = model_vec(32'h70, 32'd1);
        @(negedge clk);
        drive_start(32'h70, 32'd1);
        wait_done(LAT + 5, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_first_timeout: done=0, required 1"); end
        drive_start(32'h20, 32'd1);
        for (int i = 1; i < LAT; i++) begin
            checks++;
            if (vec_out !== first) begin
                errors++;
                $display("FAIL b2b_hold: got=%h, required %h", vec_out, first);
            end
            @(negedge clk);
        end
        checks++;
        if (vec_out !== first) begin errors++; $display("FAIL b2b_hold_last: got=%h, required %h", vec_out, first); end
        wait_done(5, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_second_timeout: done=0, required 1"); end
    endtask

    task automatic test_wrap();
        bit ok;
        fill_ram(32'hFFFF_FFFC, 32'd1);
        @(negedge clk);
        drive_start(32'hFFFF_FFFC, 32'd1);
        wait_done(LAT + 5, ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL wrap_timeout: done=0, required 1"); end
        if (exp_addr_q.size() !== 0) begin errors++; $display("FAIL wrap_addr_left: got=%0d, required 0", exp_addr_q.size()); end
    endtask

    task automatic test_mid_reset();
        bit ok;
        fill_ram(32'h10, 32'd1);
        @(negedge clk);
        drive_start(32'h10, 32'd1);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_addr_q.delete();
        exp_vec_q.delete();
        reset = 1'b1;
        checks += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: got=%b, required 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL mrst_done: got=%b, required 0", done); end
        if (mem_rden !== 1'b0) begin errors++; $display("FAIL mrst_rden: got=%b, required 0", mem_rden); end
        if (mem_addr !== '0) begin errors++; $display("FAIL mrst_addr: got=%h, required 0", mem_addr); end
        if (vec_out !== '0) begin errors++; $display("FAIL mrst_vec: got=%h, required 0", vec_out); end
        done_cnt = 0;
        repeat (LAT + 5) @(negedge clk);
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL mrst_no_done: got=%0d, required 0", done_cnt); end
        drive_start(32'h10, 32'd1);
        wait_done(LAT + 5, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mrst_restart_timeout: done=0, required 1"); end
    endtask

`ifdef VGATHER_STRIDE_EN
    task automatic test_stride();
        bit ok;
        fill_ram(32'h100, 32'd3);
        @(negedge clk);
        drive_start(32'h100, 32'd3);
        wait_done(LAT + 5, ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL stride_timeout: done=0, required 1"); end
        if (exp_addr_q.size() !== 0) begin errors++; $display("FAIL stride_addr_left: got=%0d, required 0", exp_addr_q.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_sign();
        test_busy_start();
        test_back_to_back();
        test_wrap();
        test_mid_reset();
`ifdef VGATHER_STRIDE_EN
        test_stride();
`endif
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
